// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue: buffers completed MEM-stage results, extracts
// sub-word load data at enqueue, and retires one entry per cycle to the register file.
module wb_commit_queue #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    commit_stall,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_sel,
  input  logic                    in_ld_reg,
  input  logic                    in_mem_write,
  input  logic [4:0]              in_rd,
  input  logic [XLEN-1:0]         in_alu_out,
  input  logic                    in_br_en,
  input  logic [XLEN-1:0]         in_u_imm,
  input  logic [XLEN-1:0]         in_mem_rdata,
  input  logic [1:0]              in_addr_lo,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [ORDER_W-1:0]      in_order,
  output logic                    rf_we,
  output logic [4:0]              rf_rd,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    commit_valid,
  output logic [ORDER_W-1:0]      commit_order,
  output logic [XLEN-1:0]         commit_pc,
  output logic [ORDER_W-1:0]      instret,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic                ent_we_q    [DEPTH];
  logic [4:0]          ent_rd_q    [DEPTH];
  logic [XLEN-1:0]     ent_wdata_q [DEPTH];
  logic [ORDER_W-1:0]  ent_order_q [DEPTH];
  logic [XLEN-1:0]     ent_pc_q    [DEPTH];

  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [ORDER_W-1:0]  last_order_q, last_order_d;
  logic                last_valid_q, last_valid_d;
  logic [ORDER_W-1:0]  instret_q, instret_d;

  logic                enq;
  logic                present;
  logic                dup;
  logic                new_we;
  logic [XLEN-1:0]     new_wdata;

  function automatic logic [XLEN-1:0] wb_data(
    input logic [3:0]      sel,
    input logic [XLEN-1:0] alu_out,
    input logic            br_en,
    input logic [XLEN-1:0] u_imm,
    input logic [XLEN-1:0] mem_rdata,
    input logic [1:0]      addr_lo,
    input logic [XLEN-1:0] pc
  );
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    lbyte = mem_rdata[{addr_lo, 3'b000} +: 8];
    lhalf = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    case (sel)
      4'd0:    wb_data = alu_out;
      4'd1:    wb_data = {{(XLEN-1){1'b0}}, br_en};
      4'd2:    wb_data = u_imm;
      4'd3:    wb_data = mem_rdata;
      4'd4:    wb_data = pc + XLEN'(4);
      4'd5:    wb_data = {{(XLEN-8){lbyte[7]}}, lbyte};
      4'd6:    wb_data = {{(XLEN-8){1'b0}}, lbyte};
      4'd7:    wb_data = {{(XLEN-16){lhalf[15]}}, lhalf};
      4'd8:    wb_data = {{(XLEN-16){1'b0}}, lhalf};
      default: wb_data = {XLEN{1'b0}};
    endcase
  endfunction

  assign in_ready = (count_q < FULL_C);
  assign count    = count_q;
  assign instret  = instret_q;

  // Stores never write rd, so their payload is forced to zero here rather than at retire.
  always_comb begin
    new_we    = in_ld_reg && !in_mem_write && (in_rd != 5'd0);
    new_wdata = {XLEN{1'b0}};
    if (in_mem_write) begin
      new_wdata = {XLEN{1'b0}};
    end else begin
      new_wdata = wb_data(in_sel, in_alu_out, in_br_en, in_u_imm, in_mem_rdata, in_addr_lo, in_pc);
    end
  end

  // Head presentation and retire outputs
  always_comb begin
    present      = (count_q != {CW{1'b0}}) && !commit_stall && !flush;
    dup          = last_valid_q && (ent_order_q[head_q] == last_order_q);
    rf_we        = 1'b0;
    rf_rd        = 5'd0;
    rf_wdata     = {XLEN{1'b0}};
    commit_valid = 1'b0;
    commit_order = {ORDER_W{1'b0}};
    commit_pc    = {XLEN{1'b0}};
    if (present) begin
      rf_we        = ent_we_q[head_q] && !dup;
      rf_rd        = ent_rd_q[head_q];
      rf_wdata     = ent_wdata_q[head_q];
      commit_valid = !dup;
      commit_order = ent_order_q[head_q];
      commit_pc    = ent_pc_q[head_q];
    end else begin
      rf_we        = 1'b0;
      commit_valid = 1'b0;
    end
  end

  // Pointer, occupancy and retire-counter next state
  always_comb begin
    enq          = in_valid && in_ready && !flush;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    last_order_d = last_order_q;
    last_valid_d = last_valid_q;
    instret_d    = instret_q;
    if (flush) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (present) begin
        head_d = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
      if (enq) begin
        tail_d = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      case ({enq, present})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (present && !dup) begin
        last_order_d = ent_order_q[head_q];
        last_valid_d = 1'b1;
        instret_d    = instret_q + ORDER_W'(1);
      end else begin
        last_order_d = last_order_q;
        last_valid_d = last_valid_q;
        instret_d    = instret_q;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= {AW{1'b0}};
      tail_q       <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      last_order_q <= {ORDER_W{1'b0}};
      last_valid_q <= 1'b0;
      instret_q    <= {ORDER_W{1'b0}};
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      last_order_q <= last_order_d;
      last_valid_q <= last_valid_d;
      instret_q    <= instret_d;
    end
  end

  // Entry payload storage; only slots below count are ever read, so no reset.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      ent_we_q[tail_q]    <= new_we;
      ent_rd_q[tail_q]    <= in_rd;
      ent_wdata_q[tail_q] <= new_wdata;
      ent_order_q[tail_q] <= in_order;
      ent_pc_q[tail_q]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed scenarios plus randomized
// traffic compared each cycle against a queue-based reference model.
module tb_wb_commit_queue;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int ORDER_W = 64;

  logic         clk = 1'b0;
  logic         rst, flush, commit_stall, in_valid, in_ready;
  logic [3:0]   in_sel;
  logic         in_ld_reg, in_mem_write, in_br_en;
  logic [4:0]   in_rd;
  logic [31:0]  in_alu_out, in_u_imm, in_mem_rdata, in_pc;
  logic [1:0]   in_addr_lo;
  logic [63:0]  in_order;
  logic         rf_we, commit_valid;
  logic [4:0]   rf_rd;
  logic [31:0]  rf_wdata, commit_pc;
  logic [63:0]  commit_order, instret;
  logic [2:0]   count;

  always #5 clk = ~clk;

  wb_commit_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .commit_stall(commit_stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_ld_reg(in_ld_reg),
    .in_mem_write(in_mem_write), .in_rd(in_rd), .in_alu_out(in_alu_out), .in_br_en(in_br_en),
    .in_u_imm(in_u_imm), .in_mem_rdata(in_mem_rdata), .in_addr_lo(in_addr_lo), .in_pc(in_pc),
    .in_order(in_order), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_order(commit_order), .commit_pc(commit_pc),
    .instret(instret), .count(count)
  );

  typedef struct {
    logic [63:0] order;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  ent_t        mq[$];
  bit          m_last_v;
  logic [63:0] m_last;
  logic [63:0] m_instret;
  int          checks = 0;
  int          passed = 0;
  int          failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write data from the selection rules, using shifts and masks.
  function automatic logic [31:0] ref_wdata(input logic [3:0] sel, input logic mw,
      input logic [31:0] alu, input logic br, input logic [31:0] uimm,
      input logic [31:0] rdata, input logic [1:0] a, input logic [31:0] pc);
    logic [31:0] b, h;
    b = (rdata >> (8 * a)) & 32'h0000_00FF;
    h = (rdata >> (16 * (a / 2))) & 32'h0000_FFFF;
    if (mw) return 32'd0;
    case (int'(sel))
      0: return alu;
      1: return br ? 32'd1 : 32'd0;
      2: return uimm;
      3: return rdata;
      4: return pc + 32'd4;
      5: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      6: return b;
      7: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      8: return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_in(input logic [3:0] sel, input logic ld, input logic mw,
      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
      input logic [1:0] alo, input logic [31:0] pc, input logic [63:0] ord);
    in_valid = 1'b1; in_sel = sel; in_ld_reg = ld; in_mem_write = mw; in_rd = rd;
    in_alu_out = alu; in_br_en = alu[0]; in_u_imm = ~alu; in_mem_rdata = rdata;
    in_addr_lo = alo; in_pc = pc; in_order = ord;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock cycle: compare outputs to the model, then advance the model at the edge.
  task automatic cycle();
    ent_t h, n;
    bit   pres, dup, enq;
    #1;
    h = '{order: 64'd0, pc: 32'd0, we: 1'b0, rd: 5'd0, wdata: 32'd0};
    if (mq.size() > 0) h = mq[0];
    pres = (mq.size() > 0) && !commit_stall && !flush;
    dup  = pres && m_last_v && (h.order == m_last);
    chk("in_ready", in_ready, (mq.size() < DEPTH) ? 1'b1 : 1'b0);
    chk("count", count, mq.size());
    chk("instret", instret, m_instret);
    chk("rf_we", rf_we, pres && !dup && h.we);
    chk("rf_rd", rf_rd, pres ? h.rd : 5'd0);
    chk("rf_wdata", rf_wdata, pres ? h.wdata : 32'd0);
    chk("commit_valid", commit_valid, pres && !dup);
    chk("commit_order", commit_order, pres ? h.order : 64'd0);
    chk("commit_pc", commit_pc, pres ? h.pc : 32'd0);
    enq = in_valid && (mq.size() < DEPTH) && !flush;
    n.order = in_order; n.pc = in_pc; n.rd = in_rd;
    n.we    = in_ld_reg && !in_mem_write && (in_rd != 5'd0);
    n.wdata = ref_wdata(in_sel, in_mem_write, in_alu_out, in_br_en, in_u_imm,
                        in_mem_rdata, in_addr_lo, in_pc);
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_last_v = 1'b0; m_instret = 64'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (pres) begin
        void'(mq.pop_front());
        if (!dup) begin
          m_last = h.order; m_last_v = 1'b1; m_instret = m_instret + 64'd1;
        end
      end
      if (enq) mq.push_back(n);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  ld_sel [5] = '{4'd5, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [1:0]  ld_a   [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] ld_exp [5] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF,
                                32'hFFFF_80FF, 32'h0000_7F01};
    logic [63:0] base, ctr, prev;
    int ncv, nwe;

    rst = 1'b1; flush = 1'b0; commit_stall = 1'b0;
    set_in(4'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 32'd0, 64'd0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mq.delete(); m_last_v = 1'b0; m_instret = 64'd0; m_last = 64'd0;

    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_commit_valid", commit_valid, 1'b0);
    cycle();

    // Basic ALU writeback
    set_in(4'd0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'd0, 2'd0, 32'h100, 64'd0);
    cycle();
    idle();
    #1;
    chk("t1_rf_we", rf_we, 1'b1);
    chk("t1_rf_rd", rf_rd, 5'd5);
    chk("t1_rf_wdata", rf_wdata, 32'h1234);
    chk("t1_commit_valid", commit_valid, 1'b1);
    chk("t1_commit_order", commit_order, 64'd0);
    cycle();
    #1 chk("t1_instret", instret, 64'd1);
    cycle();

    // Sub-word loads
    for (int i = 0; i < 5; i++) begin
      set_in(ld_sel[i], 1'b1, 1'b0, 5'd6, 32'd0, 32'h80FF_7F01, ld_a[i], 32'h200, 64'(i + 1));
      cycle();
      idle();
      #1 chk("load_wdata", rf_wdata, ld_exp[i]);
      cycle();
    end

    // Fill under stall, then drain in order
    commit_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(4'd0, 1'b1, 1'b0, 5'(i + 1), 32'(i), 32'd0, 2'd0, 32'(i * 4), 64'(10 + i));
      cycle();
    end
    idle();
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_count", count, 3'd4);
    chk("full_rf_we", rf_we, 1'b0);
    cycle();
    commit_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_commit_valid", commit_valid, 1'b1);
      chk("drain_order", commit_order, 64'(10 + i));
      if (i == 1) chk("drain_in_ready", in_ready, 1'b1);
      cycle();
    end

    // Duplicate order suppression
    base = m_instret; ncv = 0; nwe = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 2) set_in(4'd0, 1'b1, 1'b0, 5'd7, 32'hABCD, 32'd0, 2'd0, 32'h300, 64'd7);
      else idle();
      #1;
      ncv += int'(commit_valid);
      nwe += int'(rf_we);
      cycle();
    end
    chk("dup_commits", 64'(ncv), 64'd1);
    chk("dup_writes", 64'(nwe), 64'd1);
    chk("dup_instret", instret - base, 64'd1);
    chk("dup_count", count, 3'd0);

    // Store, rd=0, pc+4 wrap
    set_in(4'd0, 1'b1, 1'b1, 5'd3, 32'h55, 32'd0, 2'd0, 32'h400, 64'd40);
    cycle(); idle();
    #1 chk("store_rf_we", rf_we, 1'b0); chk("store_cv", commit_valid, 1'b1);
    cycle();
    set_in(4'd0, 1'b1, 1'b0, 5'd0, 32'h66, 32'd0, 2'd0, 32'h404, 64'd41);
    cycle(); idle();
    #1 chk("rd0_rf_we", rf_we, 1'b0); chk("rd0_cv", commit_valid, 1'b1);
    cycle();
    set_in(4'd4, 1'b1, 1'b0, 5'd9, 32'd0, 32'd0, 2'd0, 32'hFFFF_FFFC, 64'd42);
    cycle(); idle();
    #1 chk("pc4_wdata", rf_wdata, 32'd0); chk("pc4_rf_we", rf_we, 1'b1);
    cycle();

    // Flush with 3 entries and a concurrent input
    commit_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(4'd0, 1'b1, 1'b0, 5'd10, 32'(i), 32'd0, 2'd0, 32'h500, 64'(50 + i));
      cycle();
    end
    base = m_instret;
    commit_stall = 1'b0; flush = 1'b1;
    set_in(4'd0, 1'b1, 1'b0, 5'd11, 32'd9, 32'd0, 2'd0, 32'h510, 64'd53);
    #1 chk("flush_cv", commit_valid, 1'b0); chk("flush_rf_we", rf_we, 1'b0);
    cycle();
    flush = 1'b0; idle();
    #1 chk("flush_count", count, 3'd0); chk("flush_instret", instret, base);
    cycle();
    set_in(4'd0, 1'b1, 1'b0, 5'd12, 32'd77, 32'd0, 2'd0, 32'h520, 64'd54);
    cycle(); idle();
    #1 chk("post_flush_cv", commit_valid, 1'b1); chk("post_flush_order", commit_order, 64'd54);
    cycle();

    // Mid-operation reset
    commit_stall = 1'b1;
    set_in(4'd0, 1'b1, 1'b0, 5'd13, 32'd1, 32'd0, 2'd0, 32'h600, 64'd60);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; commit_stall = 1'b0; idle();
    #1 chk("rst_mid_count", count, 3'd0); chk("rst_mid_instret", instret, 64'd0);
    cycle();

    // Randomized traffic
    ctr = 64'd100; prev = 64'd100;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ctr = prev;
      else ctr = prev + 64'd1;
      prev = ctr;
      set_in(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 4) == 0),
             5'($urandom), $urandom, $urandom, 2'($urandom), $urandom, ctr);
      in_valid     = ($urandom_range(0, 9) < 7);
      commit_stall = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; commit_stall = 1'b0; idle();
    repeat (6) cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
